// File: rtl/vector_multiply_writeback.sv
// Vector multiply writeback: sequences products onto the 64-bit VRF write port.
// Optional perf counters when VMUL_WB_PERF_COUNTERS_EN is defined.
module vector_multiply_writeback #(
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 5,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_vd,
    input  logic [DATA_WIDTH-1:0] in_vd_high,
    input  logic                  in_widening,
    input  logic [ADDR_WIDTH-1:0] in_vd_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic [BE_WIDTH-1:0]   in_be_high,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [BE_WIDTH-1:0]   wb_be,
    output logic                  err_misaligned,
    output logic                  busy
`ifdef VMUL_WB_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_beats,
    output logic [31:0]           perf_stalls
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t                state;
    logic                  pending_widening;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [BE_WIDTH-1:0]   hold_be;

    logic accept;
    logic misaligned;
    logic advance_high;

    // The stage frees up whenever its last outstanding beat retires this cycle.
    assign in_ready = rst_n &&
                      ((state == IDLE) ||
                       (state == LOW && !pending_widening && wb_ready) ||
                       (state == HIGH && wb_ready));

    assign accept       = in_valid && in_ready;
    assign misaligned   = in_widening && in_vd_addr[0];
    assign advance_high = (state == LOW) && pending_widening && wb_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            pending_widening <= 1'b0;
            hold_data        <= '0;
            hold_be          <= '0;
            wb_valid         <= 1'b0;
            wb_addr          <= '0;
            wb_data          <= '0;
            wb_be            <= '0;
            err_misaligned   <= 1'b0;
            busy             <= 1'b0;
        end else begin
            err_misaligned <= accept && misaligned;
            if (accept) begin
                hold_data <= in_vd_high;
                hold_be   <= in_be_high;
            end
            if (advance_high) begin
                // Low address is even, so +1 is just setting bit 0.
                state            <= HIGH;
                pending_widening <= 1'b0;
                wb_addr          <= wb_addr | ADDR_WIDTH'(1);
                wb_data          <= hold_data;
                wb_be            <= hold_be;
            end else if (accept && !misaligned) begin
                state            <= LOW;
                busy             <= 1'b1;
                wb_valid         <= 1'b1;
                pending_widening <= in_widening;
                wb_addr          <= in_vd_addr;
                wb_data          <= in_vd;
                wb_be            <= in_be;
            end else if (in_ready) begin
                state            <= IDLE;
                busy             <= 1'b0;
                wb_valid         <= 1'b0;
                pending_widening <= 1'b0;
            end
        end
    end

`ifdef VMUL_WB_PERF_COUNTERS_EN
    // Saturating counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (wb_valid && wb_ready && perf_beats != '1)
                perf_beats <= perf_beats + 32'd1;
            if (wb_valid && !wb_ready && perf_stalls != '1)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_multiply_writeback.sv
// Bench for vector_multiply_writeback: beat-queue model plus directed vectors.
module tb_vector_multiply_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_vd;
    logic [63:0] in_vd_high;
    logic        in_widening;
    logic [4:0]  in_vd_addr;
    logic [7:0]  in_be;
    logic [7:0]  in_be_high;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [7:0]  wb_be;
    logic        err_misaligned;
    logic        busy;
`ifdef VMUL_WB_PERF_COUNTERS_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_stalls;
`endif

    always #5 clk = ~clk;

    vector_multiply_writeback dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_vd          (in_vd),
        .in_vd_high     (in_vd_high),
        .in_widening    (in_widening),
        .in_vd_addr     (in_vd_addr),
        .in_be          (in_be),
        .in_be_high     (in_be_high),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_be          (wb_be),
        .err_misaligned (err_misaligned),
        .busy           (busy)
`ifdef VMUL_WB_PERF_COUNTERS_EN
        ,
        .perf_beats     (perf_beats),
        .perf_stalls    (perf_stalls)
`endif
    );

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    beat_t q[$];
    bit    err_exp;
    int    n_checks;
    int    n_fail;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: list of beats still owed to the register file.
    always @(posedge clk) begin : model
        bit rdy;
        bit take;
        bit odd;
        if (!rst_n) begin
            q.delete();
            err_exp <= 1'b0;
        end else begin
            rdy  = (q.size() == 0) || (q.size() == 1 && wb_ready);
            take = in_valid && rdy;
            odd  = in_widening && in_vd_addr[0];
            if (q.size() != 0 && wb_ready)
                void'(q.pop_front());
            err_exp <= take && odd;
            if (take && !odd) begin
                q.push_back(beat_t'{in_vd_addr, in_vd, in_be});
                if (in_widening)
                    q.push_back(beat_t'{in_vd_addr | 5'd1,
                                        in_vd_high, in_be_high});
            end
        end
    end

    always @(negedge clk) begin
        #2;
        chk("wb_valid", wb_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("err_misaligned", err_misaligned, err_exp);
        chk("in_ready", in_ready,
            rst_n && (q.size() == 0 || (q.size() == 1 && wb_ready)));
        if (q.size() != 0) begin
            chk("wb_addr", wb_addr, q[0].addr);
            chk("wb_data", wb_data, q[0].data);
            chk("wb_be", wb_be, q[0].be);
        end
    end

    task automatic drive(input logic wide, input logic [4:0] a,
                         input logic [63:0] d, input logic [63:0] dh,
                         input logic [7:0] b, input logic [7:0] bh);
        in_valid    = 1'b1;
        in_widening = wide;
        in_vd_addr  = a;
        in_vd       = d;
        in_vd_high  = dh;
        in_be       = b;
        in_be_high  = bh;
    endtask

    task automatic beat(input string name, input logic [4:0] a,
                        input logic [63:0] d, input logic [7:0] b);
        chk({name, "_valid"}, wb_valid, 1'b1);
        chk({name, "_addr"}, wb_addr, a);
        chk({name, "_data"}, wb_data, d);
        chk({name, "_be"}, wb_be, b);
    endtask

    logic [63:0] vec [4];

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_widening = 1'b0;
        in_vd_addr  = '0;
        in_vd       = '0;
        in_vd_high  = '0;
        in_be       = '0;
        in_be_high  = '0;
        wb_ready    = 1'b1;
        vec[0] = 64'hDEAD_BEEF_0000_0001;
        vec[1] = 64'h0000_0000_0000_0000;
        vec[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        vec[3] = 64'h1234_5678_9ABC_DEF0;

        repeat (2) @(negedge clk);
        chk("rst_valid", wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_misaligned, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_addr", wb_addr, 5'd0);
        chk("rst_data", wb_data, 64'd0);
        chk("rst_be", wb_be, 8'd0);
        rst_n = 1'b1;

        // single non-widening product
        drive(1'b0, 5'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        beat("single", 5'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
        @(negedge clk);
        chk("single_idle", busy, 1'b0);

        // widening product, two beats
        drive(1'b1, 5'd4, 64'h11, 64'h22, 8'h0F, 8'hF0);
        @(negedge clk);
        in_valid = 1'b0;
        beat("wide_lo", 5'd4, 64'h11, 8'h0F);
        #1 chk("wide_lo_ready", in_ready, 1'b0);
        @(negedge clk);
        beat("wide_hi", 5'd5, 64'h22, 8'hF0);
        @(negedge clk);
        chk("wide_idle", busy, 1'b0);

        // back-to-back, no bubbles; be=0 still issues a beat
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'(8 + i), vec[i], 64'h0, 8'(i * 3), 8'h00);
            @(negedge clk);
            beat("b2b", 5'(8 + i), vec[i], 8'(i * 3));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", busy, 1'b0);

        // misaligned widening is dropped
        drive(1'b1, 5'd7, 64'hAA, 64'hBB, 8'hFF, 8'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_valid", wb_valid, 1'b0);
        chk("mis_err", err_misaligned, 1'b1);
        @(negedge clk);
        chk("mis_err_clr", err_misaligned, 1'b0);
        drive(1'b0, 5'd9, 64'hA5, 64'h0, 8'h81, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        beat("after_mis", 5'd9, 64'hA5, 8'h81);
        @(negedge clk);

        // stall during high beat with a new product waiting
        drive(1'b1, 5'd6, 64'h33, 64'h44, 8'h3C, 8'hC3);
        @(negedge clk);
        in_valid = 1'b0;
        beat("st_lo", 5'd6, 64'h33, 8'h3C);
        @(negedge clk);
        beat("st_hi", 5'd7, 64'h44, 8'hC3);
        wb_ready = 1'b0;
        drive(1'b0, 5'd1, 64'h55, 64'h0, 8'h01, 8'h00);
        repeat (3) begin
            @(negedge clk);
            beat("st_hold", 5'd7, 64'h44, 8'hC3);
            #1 chk("st_in_ready", in_ready, 1'b0);
        end
`ifdef VMUL_WB_PERF_COUNTERS_EN
        chk("perf_stalls", perf_stalls, 32'd3);
        chk("perf_beats", perf_beats, 32'd9);
`endif
        wb_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        beat("st_next", 5'd1, 64'h55, 8'h01);
        @(negedge clk);
        chk("st_idle", busy, 1'b0);

        // reset during the low beat of a widening op
        drive(1'b1, 5'd10, 64'h66, 64'h77, 8'hFF, 8'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        beat("rs_lo", 5'd10, 64'h66, 8'hFF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_valid", wb_valid, 1'b0);
        chk("rs_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rs_no_hi", wb_valid, 1'b0);
        end

        // mixed traffic against the model
        repeat (80) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  8'($urandom), 8'($urandom));
            in_valid    = 1'($urandom_range(0, 1));
            in_widening = ($urandom_range(0, 2) == 0);
            wb_ready    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        begin
            int k;
            k = 0;
            while (busy && k < 10) begin
                @(negedge clk);
                k++;
            end
        end
        chk("drain", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_multiply_writeback.md
Name: vector_multiply_writeback

Overview:
- Downstream stage of the vector integer multiply unit.
- Registers each product (vd, vd_high) with a valid/ready handshake and sequences it onto the single 64-bit vector register file write port.
- Non-widening results are written as one beat. Widening results are written as two beats: the low half to vd_addr, the high half to vd_addr+1.
- Isolates the combinational multiplier from register-file write-port backpressure.

Parameters:
- DATA_WIDTH, 64, width of one write beat; must equal the multiply unit lane width.
- ADDR_WIDTH, 5, vector register index width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width per beat (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  product available from the multiply unit.
- in_ready  out  1  stage can accept a product this cycle.
- in_vd  in  DATA_WIDTH  low product half (vd).
- in_vd_high  in  DATA_WIDTH  high product half (vd_high); used only when in_widening=1.
- in_widening  in  1  product is a widening result (two beats).
- in_vd_addr  in  ADDR_WIDTH  destination register index.
- in_be  in  BE_WIDTH  byte enables for the low beat (mask/tail).
- in_be_high  in  BE_WIDTH  byte enables for the high beat.
- wb_valid  out  1  write beat valid.
- wb_ready  in  1  register file accepts the beat.
- wb_addr  out  ADDR_WIDTH  write register index.
- wb_data  out  DATA_WIDTH  write data.
- wb_be  out  BE_WIDTH  write byte enables.
- err_misaligned  out  1  one-cycle pulse: widening op with odd in_vd_addr was discarded.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state returns to IDLE and any pending beat is dropped.
  - wb_valid, wb_addr, wb_data, wb_be, err_misaligned and busy all reset to 0.
  - in_ready is 0 while rst_n=0.
- States:
  - IDLE: no pending beat.
  - LOW: the low beat is presented on wb_*.
  - HIGH: the high beat is presented on wb_*.
- Accept: a transfer occurs when in_valid && in_ready at a clock edge. in_vd_high and in_be_high are captured into a holding register on accept.
- in_ready is combinational and equals:
  - (state==IDLE), or
  - (state==LOW && !pending_widening && wb_ready), or
  - (state==HIGH && wb_ready).
  This allows back-to-back non-widening products at one per cycle with no bubble.
- Latency: accept at edge N gives wb_valid=1 after edge N.
- Transitions:
  - Accept, not widening -> LOW.
  - Accept, widening, in_vd_addr[0]=0 -> LOW with pending_widening set.
  - Accept, widening, in_vd_addr[0]=1 -> operation discarded, no beats issued, err_misaligned=1 for exactly the next cycle, state stays or returns to IDLE.
  - LOW, wb_ready, pending_widening -> HIGH. wb_addr becomes stored address+1 (no wrap possible because the address is even); wb_data = held high half; wb_be = held in_be_high.
  - LOW, wb_ready, not widening -> LOW if a new accept occurs in the same cycle, otherwise IDLE.
  - HIGH, wb_ready -> LOW on a simultaneous accept, otherwise IDLE.
- Backpressure: while wb_valid=1 and wb_ready=0, wb_addr, wb_data and wb_be hold stable and wb_valid stays 1.
- Byte enables: a beat with be=0 is still issued (valid write with no bytes enabled). The stage never skips a beat.
- Every output is registered except in_ready.
- busy = (state != IDLE).

Optional Feature:
- Macro: VMUL_WB_PERF_COUNTERS_EN.
- When defined, adds two outputs:
  - perf_beats (32 bits): increments on each wb_valid && wb_ready.
  - perf_stalls (32 bits): increments on each wb_valid && !wb_ready.
- Both counters reset to 0, saturate at 0xFFFFFFFF (no wrap), and are cleared by rst_n only.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Single non-widening product: in_vd=64'h0123_4567_89AB_CDEF, addr=3, be=8'hFF, wb_ready=1 -> one beat on the next cycle with addr=3 and that data; then IDLE, busy=0.
- Widening product: vd=64'h11, vd_high=64'h22, addr=4, be=8'h0F, be_high=8'hF0 -> beat (4, 64'h11, 8'h0F), then beat (5, 64'h22, 8'hF0); in_ready=0 during the low beat.
- Four back-to-back non-widening products, in_valid held high, wb_ready=1 -> four consecutive beats at one per cycle, no bubbles.
- Widening with addr=7 -> no wb_valid; err_misaligned high for exactly one cycle; next op accepted normally.
- wb_ready held 0 for 3 cycles during the high beat -> wb_* stable, in_ready=0; perf_stalls=3 when VMUL_WB_PERF_COUNTERS_EN is defined.
- rst_n=0 asserted during LOW of a widening op -> next cycle wb_valid=0, busy=0; high beat never issued.
